// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer: per-image controller that streams pixels from memory
// into the network input buffer, launches neural_net, waits for the class
// (with a timeout) and hands the result downstream. Images are chained with
// auto_run or run one at a time with start; the image index wraps.
//
// Result handshake: res_valid rises in RESULT and stays high, with res_class,
// res_err and res_image frozen, until a cycle in which res_ready is also high.
// That cycle is the transfer (including the very first RESULT cycle).
// res_valid never drops without a transfer, except on rst.
module nn_inference_sequencer #(
    parameter int IN_WIDTH       = 784,
    parameter int NUM_IMAGES     = 4,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IMG_W         = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_run,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              pix_wr_en,
    output logic [9:0]        pix_wr_idx,
    output logic [7:0]        pix_wr_data,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic [3:0]        nn_class,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_class,
    output logic              res_err,
    output logic [IMG_W-1:0]  res_image,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_LAUNCH,
        S_COMPUTE,
        S_RESULT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [9:0]         pix_cnt;
    logic [TW-1:0]      tmo_cnt;
    logic [ADDR_W-1:0]  base_addr;
    logic [IMG_W-1:0]   img_idx;
    logic               wr_en_q;
    logic [9:0]         wr_idx_q;
    logic [3:0]         res_class_q;
    logic               res_err_q;
    logic [IMG_W-1:0]   res_image_q;

    logic fetch_last;
    logic timeout_hit;
    logic accept;

    assign fetch_last  = (pix_cnt == 10'(IN_WIDTH - 1));
    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign accept      = (state == S_RESULT) && res_ready;

    // State register; rst aborts any image straight back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        nn_start  = 1'b0;
        res_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start || auto_run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_addr + ADDR_W'(pix_cnt);
                if (fetch_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                nn_start  = 1'b1;
                state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (nn_done || timeout_hit) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = auto_run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel counter and the 1-deep write pipeline that lines the index up
    // with memory read data arriving one cycle after the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt  <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            pix_cnt  <= (state == S_FETCH && !fetch_last) ? pix_cnt + 10'd1 : '0;
            wr_en_q  <= (state == S_FETCH);
            wr_idx_q <= (state == S_FETCH) ? pix_cnt : '0;
        end
    end

    assign pix_wr_en   = wr_en_q;
    assign pix_wr_idx  = wr_idx_q;
    assign pix_wr_data = wr_en_q ? mem_rd_data : 8'h00;

    // Compute timeout counter and result capture; nn_done beats the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            res_class_q <= '0;
            res_err_q   <= 1'b0;
            res_image_q <= '0;
        end else if (state == S_LAUNCH) begin
            tmo_cnt <= '0;
        end else if (state == S_COMPUTE) begin
            if (nn_done) begin
                res_class_q <= nn_class;
                res_err_q   <= 1'b0;
                res_image_q <= img_idx;
            end else if (timeout_hit) begin
                res_class_q <= 4'hF;
                res_err_q   <= 1'b1;
                res_image_q <= img_idx;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    assign res_class = res_class_q;
    assign res_err   = res_err_q;
    assign res_image = res_image_q;

    // Image index and base address step on each accepted result, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_idx   <= '0;
            base_addr <= '0;
        end else if (accept) begin
            if (img_idx == IMG_W'(NUM_IMAGES - 1)) begin
                img_idx   <= '0;
                base_addr <= '0;
            end else begin
                img_idx   <= img_idx + IMG_W'(1);
                base_addr <= base_addr + ADDR_W'(IN_WIDTH);
            end
        end
    end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Bench for nn_inference_sequencer: random memory contents, random network
// latency/class, random downstream stalls, compared every cycle against a
// timeline model of one image (cycle offset since the start edge).
module tb_nn_inference_sequencer;

    localparam int IN_WIDTH       = 784;
    localparam int NUM_IMAGES     = 4;
    localparam int ADDR_W         = 16;
    localparam int TIMEOUT_CYCLES = 1024;

    // ---------------- clock / reset / signals ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              auto_run = 1'b0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              pix_wr_en;
    logic [9:0]        pix_wr_idx;
    logic [7:0]        pix_wr_data;
    logic              nn_start;
    logic              nn_done;
    logic [3:0]        nn_class = 4'd0;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_class;
    logic              res_err;
    logic [1:0]        res_image;
    logic              busy;

    always #5 clk = ~clk;

    nn_inference_sequencer #(
        .IN_WIDTH(IN_WIDTH),
        .NUM_IMAGES(NUM_IMAGES),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .auto_run(auto_run),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_wr_en(pix_wr_en), .pix_wr_idx(pix_wr_idx), .pix_wr_data(pix_wr_data),
        .nn_start(nn_start), .nn_done(nn_done), .nn_class(nn_class),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_err(res_err), .res_image(res_image), .busy(busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- environment: memory, network, downstream ----------------
    logic [7:0] mem [0:4095];

    always @(posedge clk) mem_rd_data <= (mem_rd_en === 1'b1) ? mem[mem_addr[11:0]] : 8'h00;

    int   resp_mode = 2;      // 0 random latency/class, 1 never answer, 2 fixed
    int   fix_delay = 3;
    logic [3:0] fix_class = 4'd7;
    logic resp_done = 1'b0;
    logic noise_done = 1'b0;
    logic noise_en = 1'b0;
    assign nn_done = resp_done | noise_done;

    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (nn_start === 1'b1 && resp_mode != 1) begin
                d = (resp_mode == 2) ? fix_delay : $urandom_range(1, 12);
                repeat (d) @(negedge clk);
                resp_done = 1'b1;
                nn_class  = (resp_mode == 2) ? fix_class : 4'($urandom_range(0, 9));
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        noise_done = noise_en && ($urandom_range(0, 15) == 0);
    end

    logic rdy_main = 1'b0;
    logic rdy_rand = 1'b0;
    logic rdy_r    = 1'b0;
    assign res_ready = rdy_rand ? rdy_r : rdy_main;

    initial forever begin
        @(negedge clk);
        rdy_r = ($urandom_range(0, 2) != 0);
    end

    // ---------------- behavioural model ----------------
    // m_off: cycles since the start edge (1..IN_WIDTH fetch, +1 drain,
    // +2 launch, IN_WIDTH+3 while computing); m_inres: result on offer.
    bit         m_run = 0, m_inres = 0;
    int         m_off = 0, m_wait = 0, m_img = 0, m_base = 0, m_rimg = 0;
    logic [3:0] m_cls = 4'd0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 0; m_inres <= 0; m_off <= 0; m_wait <= 0;
            m_img <= 0; m_base <= 0; m_rimg <= 0; m_cls <= 4'd0; m_err <= 1'b0;
        end else if (!m_run) begin
            if (start || auto_run) begin
                m_run <= 1; m_off <= 1;
            end
        end else if (m_inres) begin
            if (res_ready) begin
                m_img   <= (m_img + 1) % NUM_IMAGES;
                m_base  <= ((m_img + 1) % NUM_IMAGES) * IN_WIDTH;
                m_inres <= 0;
                if (auto_run) m_off <= 1;
                else begin m_run <= 0; m_off <= 0; end
            end
        end else if (m_off <= IN_WIDTH + 2) begin
            m_off  <= m_off + 1;
            m_wait <= 0;
        end else if (nn_done) begin
            m_inres <= 1; m_cls <= nn_class; m_err <= 1'b0; m_rimg <= m_img;
        end else if (m_wait == TIMEOUT_CYCLES - 1) begin
            m_inres <= 1; m_cls <= 4'hF; m_err <= 1'b1; m_rimg <= m_img;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    logic [15:0] fetch_q[$];   // first address of every fetch burst seen
    logic [6:0]  res_q[$];     // accepted {err, class, image}
    logic [6:0]  exp_q[$];     // expected accepted results
    int          start_cyc = -1;
    logic        prev_rd = 1'b0, prev_valid = 1'b0, prev_err = 1'b0;
    logic [3:0]  prev_cls = 4'd0;
    logic [1:0]  prev_img = 2'd0;

    always @(posedge clk) begin
        bit e_fetch, e_wr, e_ns;
        #1;
        if (chk_en) begin
            e_fetch = m_run && !m_inres && m_off >= 1 && m_off <= IN_WIDTH;
            e_wr    = m_run && !m_inres && m_off >= 2 && m_off <= IN_WIDTH + 1;
            e_ns    = m_run && !m_inres && m_off == IN_WIDTH + 2;
            chk("busy", 32'(busy), 32'(m_run));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(e_fetch));
            chk("mem_addr", 32'(mem_addr), e_fetch ? 32'(m_base + m_off - 1) : 32'd0);
            chk("pix_wr_en", 32'(pix_wr_en), 32'(e_wr));
            if (e_wr) begin
                chk("pix_wr_idx", 32'(pix_wr_idx), 32'(m_off - 2));
                chk("pix_wr_data", 32'(pix_wr_data), 32'(mem[m_base + m_off - 2]));
            end
            chk("nn_start", 32'(nn_start), 32'(e_ns));
            chk("res_valid", 32'(res_valid), 32'(m_inres));
            if (m_inres) begin
                chk("res_class", 32'(res_class), 32'(m_cls));
                chk("res_err", 32'(res_err), 32'(m_err));
                chk("res_image", 32'(res_image), 32'(m_rimg));
            end
            if (mem_rd_en && !prev_rd) fetch_q.push_back(mem_addr);
            if (nn_start) start_cyc = cyc;
            if (prev_valid && res_ready && !rst) res_q.push_back({prev_err, prev_cls, prev_img});
        end
        prev_rd    = mem_rd_en;
        prev_valid = res_valid;
        prev_err   = res_err;
        prev_cls   = res_class;
        prev_img   = res_image;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fetches(input int n, input int budget);
        int t = 0;
        while (fetch_q.size() < n && t < budget) begin @(negedge clk); t++; end
        if (fetch_q.size() < n) begin
            n_total++;
            $display("FAIL wait_fetch: saw %0d bursts, required %0d", fetch_q.size(), n);
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int t = 0;
        while (res_q.size() < n && t < budget) begin @(negedge clk); t++; end
        if (res_q.size() < n) begin
            n_total++;
            $display("FAIL wait_result: saw %0d results, required %0d", res_q.size(), n);
        end
    endtask

    task automatic check_results(input string name);
        while (exp_q.size() > 0) begin
            if (res_q.size() == 0) begin
                n_total++;
                $display("FAIL %s: result missing, required %0h", name, exp_q.pop_front());
            end else begin
                chk(name, 32'(res_q.pop_front()), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0, t;
        logic [6:0] r;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        // reset state
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pix_wr_en", 32'(pix_wr_en), 32'd0);
        chk("rst_nn_start", 32'(nn_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_class", 32'(res_class), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_res_image", 32'(res_image), 32'd0);
        rst = 1'b0;

        // single shot, class 7 three cycles after launch, ready tied high
        rdy_main = 1'b1;
        resp_mode = 2;
        @(negedge clk);
        t0 = cyc;
        pulse_start();
        wait_results(1, 2000);
        chk("t1_first_addr", 32'(fetch_q[0]), 32'd0);
        chk("t1_launch_latency", 32'(start_cyc - t0), 32'd786);
        exp_q.push_back({1'b0, 4'd7, 2'd0});
        check_results("t1_result");

        // second single shot continues from the next image
        resp_mode = 0;
        @(negedge clk);
        pulse_start();
        wait_results(1, 2000);
        chk("t1b_second_addr", 32'(fetch_q[1]), 32'd784);
        r = res_q.pop_front();
        chk("t1b_image", 32'(r[1:0]), 32'd1);
        chk("t1b_err", 32'(r[6]), 32'd0);

        // free-running over all images with wrap, then drop auto_run mid-image
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fetch_q.delete();
        res_q.delete();
        auto_run = 1'b1;
        wait_fetches(5, 6000);
        auto_run = 1'b0;
        wait_results(5, 2000);
        for (int i = 0; i < 5; i++) begin
            chk("t2_fetch_base", 32'(fetch_q[i]), 32'((i % 4) * IN_WIDTH));
            exp_q.push_back(res_q[i]);
        end
        for (int i = 0; i < 5; i++) begin
            r = exp_q.pop_front();
            chk("t2_image_seq", 32'(r[1:0]), 32'(i % 4));
        end
        repeat (5) @(negedge clk);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_no_refetch", 32'(fetch_q.size()), 32'd5);

        // timeout, then a long downstream stall with ignored start / nn_done
        fetch_q.delete();
        res_q.delete();
        resp_mode = 1;
        rdy_main = 1'b0;
        pulse_start();
        t = 0;
        while (res_valid !== 1'b1 && t < 2500) begin @(negedge clk); t++; end
        chk("t3_timeout_latency", 32'(cyc - start_cyc), 32'd1025);
        for (int i = 0; i < 20; i++) begin
            start    = (i == 5 || i == 12);
            noise_en = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        noise_en = 1'b0;
        chk("t3_hold_valid", 32'(res_valid), 32'd1);
        chk("t3_hold_class", 32'(res_class), 32'hF);
        chk("t3_hold_err", 32'(res_err), 32'd1);
        chk("t3_hold_image", 32'(res_image), 32'd1);
        chk("t3_no_new_fetch", 32'(fetch_q.size()), 32'd1);
        rdy_main = 1'b1;
        @(negedge clk);
        rdy_main = 1'b0;
        @(negedge clk);
        exp_q.push_back({1'b1, 4'hF, 2'd1});
        check_results("t3_result");

        // index advanced past the timed-out image; reset mid-fetch
        resp_mode = 0;
        pulse_start();
        wait_fetches(2, 50);
        chk("t4_fetch_base", 32'(fetch_q[1]), 32'd1568);
        t = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr == 16'd1868) && t < 1000) begin
            @(negedge clk); t++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("t4_rst_wr_en", 32'(pix_wr_en), 32'd0);
        rst = 1'b0;
        fetch_q.delete();
        res_q.delete();

        // random stalls and stray nn_done pulses, restart from image 0
        rdy_rand = 1'b1;
        noise_en = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_fetches(1, 50);
        chk("t5_fetch_base", 32'(fetch_q[0]), 32'd0);
        auto_run = 1'b1;
        wait_fetches(3, 4000);
        auto_run = 1'b0;
        wait_results(3, 3000);
        for (int i = 0; i < 3; i++) begin
            r = res_q.pop_front();
            chk("t5_image_seq", 32'(r[1:0]), 32'(i));
        end
        noise_en = 1'b0;
        rdy_rand = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nn_inference_sequencer.md
Name: nn_inference_sequencer

Overview:
Sequences inference over a bank of 8-bit images stored back-to-back in pixel memory, one image every IN_WIDTH bytes. For each image it streams the pixels from memory into the network's input buffer, launches neural_net, and waits for the class result. It then hands the result downstream with a valid/ready handshake and advances to the next image, wrapping after NUM_IMAGES. It replaces manual address stepping with a single-shot or free-running controller.

Parameters:
IN_WIDTH, 784, pixels per image (bytes)
NUM_IMAGES, 4, images in memory; index wraps to 0 after NUM_IMAGES-1
ADDR_W, 16, pixel memory address width
TIMEOUT_CYCLES, 1024, max COMPUTE cycles to wait for nn_done before flagging an error

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-shot request to run the current image; sampled only in IDLE
auto_run  in  1  when 1, the sequencer chains images continuously
mem_rd_en  out  1  pixel memory read enable
mem_addr  out  ADDR_W  pixel memory byte address
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
pix_wr_en  out  1  write strobe into the network input buffer
pix_wr_idx  out  10  pixel index 0..IN_WIDTH-1
pix_wr_data  out  8  pixel value
nn_start  out  1  1-cycle launch pulse to neural_net
nn_done  in  1  network result valid (pulse or level)
nn_class  in  4  class 0..9 from the network
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_class  out  4  captured class; 4'hF on timeout
res_err  out  1  1 = timeout occurred
res_image  out  max(1,$clog2(NUM_IMAGES))  index of the image that produced the result
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset: state=IDLE, img_idx=0, base_addr=0, pixel/timeout counters=0. All outputs are 0, including res_class, res_image and res_err.
- States: IDLE, FETCH, DRAIN, LAUNCH, COMPUTE, RESULT.
- IDLE: on (start | auto_run), go to FETCH next cycle. Call the sampling edge N.
- FETCH (cycles N+1 .. N+IN_WIDTH):
  - mem_rd_en=1.
  - mem_addr = base_addr + k, with k = 0..IN_WIDTH-1.
  - The last address goes to DRAIN.
- Pixel writes: pixel k is written in cycle N+2+k with pix_wr_en=1, pix_wr_idx=k, pix_wr_data=mem_rd_data. The pipeline is a 1-deep register of (en, idx).
- DRAIN (N+IN_WIDTH+1): writes the final pixel; mem_rd_en=0.
- LAUNCH (N+IN_WIDTH+2): nn_start=1 for exactly this cycle; clear the timeout counter.
- COMPUTE: wait for nn_done.
  - On nn_done: capture nn_class, set res_err=0, go to RESULT.
  - If the counter reaches TIMEOUT_CYCLES without nn_done: res_class=4'hF, res_err=1, go to RESULT.
  - If nn_done and timeout occur in the same cycle, nn_done wins.
- RESULT:
  - res_valid=1 and holds; res_class, res_err and res_image are stable until res_ready.
  - res_ready high in the first RESULT cycle is accepted that cycle.
- On acceptance:
  - If img_idx == NUM_IMAGES-1: img_idx=0, base_addr=0.
  - Otherwise: img_idx+1, base_addr += IN_WIDTH (adder, no multiplier).
  - Next state is FETCH if auto_run=1, else IDLE.
- start outside IDLE is ignored (not queued). nn_done outside COMPUTE is ignored.
- Deasserting auto_run mid-image completes the current image and handshake, then returns to IDLE.
- Reset in any state aborts immediately to reset values next cycle. No partial result is emitted, and the pixel write pipeline is flushed (pix_wr_en=0).
- Latency: start sample to nn_start = IN_WIDTH+2 cycles. nn_done to res_valid = 1 cycle.

Test Plan:
- Reset then start pulse at edge N → mem_addr 0..783 in N+1..N+784. pix_wr_idx 0..783 in N+2..N+785 with data = mem contents. nn_start only at N+786.
- Image 0, nn_done with nn_class=7 three cycles after nn_start, res_ready=1 → res_valid 1 cycle, res_class=7, res_err=0, res_image=0. Next start reads from address 784.
- auto_run=1, NUM_IMAGES=4, res_ready tied 1 → res_image sequence 0,1,2,3,0. The fifth fetch starts at address 0.
- nn_done never asserted → after 1024 COMPUTE cycles: res_valid=1, res_class=4'hF, res_err=1. Image index still advances on accept.
- res_ready held 0 for 20 cycles in RESULT → res_valid and outputs stable, no new fetch. A start pulse during this period is ignored.
- rst asserted mid-FETCH at pixel 300 → next cycle: busy=0, mem_rd_en=0, pix_wr_en=0, img_idx=0. A later start refetches from address 0.
